// File: rtl/i2c_cfg_pkg.sv
// i2c_cfg_pkg
//   Shared constants and helpers for the I2C command arbiter:
//   - default sensor slave address and word-field widths
//   - arbiter FSM state encoding
//   - control-clock divider terminal count
//   - round-robin requester pick
package i2c_cfg_pkg;

  localparam logic [7:0] SLAVE_ADDR_DEF = 8'hBA;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int WORD_W = ADDR_W + DATA_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_REL  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  function automatic int div_tc(input int clk_freq, input int i2c_freq);
    return clk_freq / i2c_freq;
  endfunction

  // First set bit of req at or after ptr, wrapping within n requesters.
  // Returns ptr when nothing is set; callers qualify with |req.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int n);
    logic [2:0] pick;
    logic [2:0] ki;
    logic found;
    int k;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      k  = (int'(ptr) + i) % n;
      ki = 3'(k);
      if ((i < n) && !found && req[ki]) begin
        pick  = ki;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/i2c_cmd_arbiter_if.sv
// i2c_cmd_arbiter_if
//   Link between the arbiter and the I2C_Controller write engine.
//   oI2C_CTRL_CLK : divided control clock to the controller
//   oI2C_DATA     : {slave addr, sub addr, data} frame
//   oI2C_GO       : start write
//   iI2C_END      : controller finished
//   iI2C_ACK      : 1 = slave NACKed
interface i2c_cmd_arbiter_if;
  logic        oI2C_CTRL_CLK;
  logic [31:0] oI2C_DATA;
  logic        oI2C_GO;
  logic        iI2C_END;
  logic        iI2C_ACK;

  modport master (
    output oI2C_CTRL_CLK, oI2C_DATA, oI2C_GO,
    input  iI2C_END, iI2C_ACK
  );

  modport slave (
    input  oI2C_CTRL_CLK, oI2C_DATA, oI2C_GO,
    output iI2C_END, iI2C_ACK
  );
endinterface

// File: rtl/i2c_cmd_arbiter_clkgen.sv
// i2c_ctrl_clkgen
//   Divides i_clk down to the I2C control clock.
//   i_clk, i_rst_n : system clock, async active-low reset
//   o_ctrl_clk     : control clock, toggles every TC+1 i_clk cycles
//   o_tick         : high in the i_clk cycle where o_ctrl_clk goes 0->1
module i2c_ctrl_clkgen #(
  parameter int TC = 2500
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_ctrl_clk,
  output logic o_tick
);

  localparam int CW = (TC > 0) ? $clog2(TC + 1) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_clk;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_clk <= 1'b0;
    end else if (r_cnt < CW'(TC)) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= '0;
      r_clk <= ~r_clk;
    end
  end

  assign o_ctrl_clk = r_clk;
  assign o_tick     = (r_cnt == CW'(TC)) && !r_clk;

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter
//   Shares one I2C_Controller among N_REQ register-write requesters.
//   Round-robin grant, wraps the 24-bit word with SLAVE_ADDR, retries
//   on NACK up to MAX_RETRY times, reports per-requester done/error.
//   iCLK, iRST_N : system clock, async active-low reset
//   iREQ         : level request per requester, held until oDONE/oERR
//   iREQ_DATA    : requester k word at [24k+23:24k]
//   oDONE, oERR  : one-iCLK completion / failure pulses
//   oBUSY        : high from grant until release
//   i2c          : controller link (clock, frame, GO, END, ACK)
//
//   state | meaning
//   IDLE  | waiting for a request on tick
//   LOAD  | frame latched, raise GO on next tick
//   RUN   | GO high, waiting for END
//   REL   | NACKed, GO low, waiting for END to drop before retry
//   FIN   | result reported, waiting for END to drop
module i2c_cmd_arbiter
  import i2c_cfg_pkg::*;
#(
  parameter int         N_REQ      = 3,
  parameter int         CLK_Freq   = 50000000,
  parameter int         I2C_Freq   = 20000,
  parameter logic [7:0] SLAVE_ADDR = SLAVE_ADDR_DEF,
  parameter int         MAX_RETRY  = 3
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic [N_REQ-1:0]        iREQ,
  input  logic [WORD_W*N_REQ-1:0] iREQ_DATA,
  output logic [N_REQ-1:0]        oDONE,
  output logic [N_REQ-1:0]        oERR,
  output logic                    oBUSY,
  i2c_cmd_arbiter_if.master       i2c
);

  localparam int TC = div_tc(CLK_Freq, I2C_Freq);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_idx, w_idx_nxt;
  logic [2:0]         r_ptr, w_ptr_nxt;
  logic [RW-1:0]      r_retry, w_retry_nxt;
  logic [31:0]        r_data, w_data_nxt;
  logic               r_go, w_go_nxt;
  logic               r_busy, w_busy_nxt;
  logic [N_REQ-1:0]   r_done, w_done_nxt;
  logic [N_REQ-1:0]   r_err, w_err_nxt;

  logic               w_tick;
  logic               w_ctrl_clk;
  logic [7:0]         w_req8;
  logic [2:0]         w_pick;
  logic [WORD_W-1:0]  w_pick_word;
  logic [2:0]         w_idx_inc;
  logic [N_REQ-1:0]   w_idx_hot;

  i2c_ctrl_clkgen #(.TC(TC)) u_clkgen (
    .i_clk      (iCLK),
    .i_rst_n    (iRST_N),
    .o_ctrl_clk (w_ctrl_clk),
    .o_tick     (w_tick)
  );

  assign w_req8      = 8'(iREQ);
  assign w_pick      = rr_pick(w_req8, r_ptr, N_REQ);
  assign w_pick_word = iREQ_DATA[WORD_W*int'(w_pick) +: WORD_W];
  assign w_idx_inc   = (r_idx == 3'(N_REQ - 1)) ? 3'd0 : r_idx + 3'd1;
  assign w_idx_hot   = N_REQ'(1) << r_idx;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_retry <= '0;
      r_data  <= '0;
      r_go    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ptr   <= w_ptr_nxt;
      r_retry <= w_retry_nxt;
      r_data  <= w_data_nxt;
      r_go    <= w_go_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ptr_nxt   = r_ptr;
    w_retry_nxt = r_retry;
    w_data_nxt  = r_data;
    w_go_nxt    = r_go;
    w_busy_nxt  = r_busy;
    w_done_nxt  = '0;
    w_err_nxt   = '0;

    case (r_state)
      S_IDLE: begin
        if (w_tick && (|iREQ)) begin
          w_idx_nxt   = w_pick;
          w_data_nxt  = {SLAVE_ADDR, w_pick_word};
          w_busy_nxt  = 1'b1;
          w_retry_nxt = '0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_tick) begin
          w_go_nxt    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_tick && i2c.iI2C_END) begin
          w_go_nxt = 1'b0;
          if (!i2c.iI2C_ACK) begin
            w_done_nxt  = w_idx_hot;
            w_busy_nxt  = 1'b0;
            w_ptr_nxt   = w_idx_inc;
            w_state_nxt = S_FIN;
          end else if (r_retry < RW'(MAX_RETRY)) begin
            w_retry_nxt = r_retry + RW'(1);
            w_state_nxt = S_REL;
          end else begin
            w_err_nxt   = w_idx_hot;
            w_busy_nxt  = 1'b0;
            w_ptr_nxt   = w_idx_inc;
            w_state_nxt = S_FIN;
          end
        end
      end
      // Entered on a tick, so the earliest exit is the following tick.
      S_REL: begin
        if (w_tick && !i2c.iI2C_END) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_FIN: begin
        if (w_tick && !i2c.iI2C_END) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign oDONE             = r_done;
  assign oERR              = r_err;
  assign oBUSY             = r_busy;
  assign i2c.oI2C_GO       = r_go;
  assign i2c.oI2C_DATA     = r_data;
  assign i2c.oI2C_CTRL_CLK = w_ctrl_clk;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
module tb_i2c_cmd_arbiter;
  import i2c_cfg_pkg::*;

  localparam int N    = 3;
  localparam int CLKF = 2;
  localparam int I2CF = 1;
  localparam int TICK = 2 * (CLKF / I2CF + 1);

  localparam logic [1:0] K_GO   = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  idx;
    logic [31:0] data;
  } exp_t;

  typedef struct packed {
    logic [2:0]  mask;
    logic [71:0] words;
    logic [8:0]  nacks;
    logic [1:0]  n_grants;
    logic [5:0]  order;
  } vec_t;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic [2:0]  iREQ;
  logic [71:0] iREQ_DATA = '0;
  logic [2:0]  oDONE, oERR;
  logic        oBUSY;

  i2c_cmd_arbiter_if u_if ();

  i2c_cmd_arbiter #(
    .N_REQ(N), .CLK_Freq(CLKF), .I2C_Freq(I2CF),
    .SLAVE_ADDR(8'hBA), .MAX_RETRY(3)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iREQ(iREQ), .iREQ_DATA(iREQ_DATA),
    .oDONE(oDONE), .oERR(oERR), .oBUSY(oBUSY), .i2c(u_if)
  );

  always #5 iCLK = ~iCLK;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t sb_q[$];
  logic ack_q[$];
  int   arm_cnt[3] = '{0, 0, 0};
  int   done_cnt[3] = '{0, 0, 0};
  vec_t vecs[6];

  always @(posedge iCLK) cyc <= cyc + 1;

  // Requester k holds its request until it has seen as many completions as arms.
  always_comb begin
    iREQ = '0;
    for (int k = 0; k < 3; k++) iREQ[k] = (arm_cnt[k] != done_cnt[k]);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_check(input exp_t got);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_unexpected: got %h expected no event (cycle %0d)", got, cyc);
    end else begin
      e = sb_q.pop_front();
      check("sb_event", 64'(got), 64'(e));
    end
  endtask

  task automatic push_go(input logic [31:0] d);
    sb_q.push_back('{kind: K_GO, idx: 2'd0, data: d});
  endtask

  task automatic push_end(input logic [1:0] kind, input int k);
    sb_q.push_back('{kind: kind, idx: 2'(k), data: 32'h0});
  endtask

  task automatic wait_sb_empty(input string name, input int budget);
    int i = 0;
    while (sb_q.size() != 0 && i < budget) begin
      @(negedge iCLK);
      i++;
    end
    check(name, 64'(sb_q.size()), 64'd0);
    sb_q.delete();
  endtask

  task automatic wait_clk_rise(output int c);
    logic p;
    p = u_if.oI2C_CTRL_CLK;
    c = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge iCLK);
      if (u_if.oI2C_CTRL_CLK && !p) begin
        c = cyc;
        break;
      end
      p = u_if.oI2C_CTRL_CLK;
    end
  endtask

  // I2C_Controller model: END a few cycles after GO, ACK from ack_q; END drops once GO drops.
  initial begin
    int dly;
    dly = 0;
    u_if.iI2C_END = 1'b0;
    u_if.iI2C_ACK = 1'b0;
    forever begin
      @(negedge iCLK);
      if (!iRST_N) begin
        u_if.iI2C_END = 1'b0;
        u_if.iI2C_ACK = 1'b0;
        dly = 0;
      end else if (u_if.oI2C_GO && !u_if.iI2C_END) begin
        if (dly >= 3) begin
          if (ack_q.size() > 0) begin
            u_if.iI2C_ACK = ack_q.pop_front();
            u_if.iI2C_END = 1'b1;
          end
        end else begin
          dly++;
        end
      end else if (!u_if.oI2C_GO) begin
        u_if.iI2C_END = 1'b0;
        u_if.iI2C_ACK = 1'b0;
        dly = 0;
      end
    end
  end

  // Output monitor: GO frames and completion pulses are popped against the scoreboard.
  initial begin
    logic prev_go, prev_busy, first_go;
    int busy_cyc;
    prev_go = 1'b0; prev_busy = 1'b0; first_go = 1'b0; busy_cyc = 0;
    forever begin
      @(negedge iCLK);
      if (!iRST_N) begin
        prev_go = 1'b0; prev_busy = 1'b0; first_go = 1'b0;
      end else begin
        if (oBUSY && !prev_busy) begin
          busy_cyc = cyc;
          first_go = 1'b1;
        end
        if (u_if.oI2C_GO && !prev_go) begin
          if (first_go) begin
            check("grant_to_go", 64'(cyc - busy_cyc), 64'(TICK));
            first_go = 1'b0;
          end
          sb_check('{kind: K_GO, idx: 2'd0, data: u_if.oI2C_DATA});
        end
        for (int k = 0; k < 3; k++) begin
          if (oDONE[k]) begin
            sb_check('{kind: K_DONE, idx: 2'(k), data: 32'h0});
            done_cnt[k]++;
          end
          if (oERR[k]) begin
            sb_check('{kind: K_ERR, idx: 2'(k), data: 32'h0});
            done_cnt[k]++;
          end
        end
        prev_go   = u_if.oI2C_GO;
        prev_busy = oBUSY;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, k, nk, att;
    vec_t v;

    vecs[0] = '{mask: 3'b001, words: {24'h0, 24'h0, 24'h090450}, nacks: 9'd0,
                n_grants: 2'd1, order: 6'd0};
    vecs[1] = '{mask: 3'b100, words: {24'h0A1234, 24'h0, 24'h0}, nacks: 9'd0,
                n_grants: 2'd1, order: {4'd0, 2'd2}};
    vecs[2] = '{mask: 3'b111, words: {24'hC30003, 24'hB20002, 24'hA10001}, nacks: 9'd0,
                n_grants: 2'd3, order: {2'd2, 2'd1, 2'd0}};
    vecs[3] = '{mask: 3'b010, words: {24'h0, 24'h3500FF, 24'h0}, nacks: {3'd0, 3'd2, 3'd0},
                n_grants: 2'd1, order: {4'd0, 2'd1}};
    vecs[4] = '{mask: 3'b101, words: {24'h218002, 24'h0, 24'h208001}, nacks: {3'd4, 3'd0, 3'd0},
                n_grants: 2'd2, order: {2'd0, 2'd0, 2'd2}};
    vecs[5] = '{mask: 3'b011, words: {24'h0, 24'h31ABCD, 24'h300003}, nacks: {3'd0, 3'd0, 3'd1},
                n_grants: 2'd2, order: {2'd0, 2'd0, 2'd1}};

    // Reset state
    repeat (3) @(negedge iCLK);
    check("rst_outputs", 64'({oBUSY, u_if.oI2C_GO, u_if.oI2C_CTRL_CLK, oDONE, oERR}), 64'd0);
    check("rst_data", 64'(u_if.oI2C_DATA), 64'd0);
    iRST_N = 1'b1;

    wait_clk_rise(c1);
    wait_clk_rise(c2);
    check("ctrl_clk_period", 64'(c2 - c1), 64'(TICK));

    // Fairness: req0 re-arms right after its done while req1 waits -> 0,1,0
    iREQ_DATA[23:0]  = 24'h112233;
    iREQ_DATA[47:24] = 24'h445566;
    push_go(32'hBA112233); push_end(K_DONE, 0);
    push_go(32'hBA445566); push_end(K_DONE, 1);
    push_go(32'hBA778899); push_end(K_DONE, 0);
    repeat (3) ack_q.push_back(1'b0);
    arm_cnt[0]++;
    arm_cnt[1]++;
    for (int i = 0; i < 400; i++) begin
      @(negedge iCLK);
      if (oDONE[0]) begin
        arm_cnt[0]++;
        iREQ_DATA[23:0] = 24'h778899;
        break;
      end
    end
    wait_sb_empty("fairness_drain", 1000);
    @(negedge iCLK);
    check("fairness_idle", 64'({oBUSY, iREQ}), 64'd0);

    // Table-driven scenarios; RR pointer carries over between rows.
    for (int t = 0; t < 6; t++) begin
      v = vecs[t];
      iREQ_DATA = v.words;
      for (int g = 0; g < int'(v.n_grants); g++) begin
        k   = int'(v.order[2*g +: 2]);
        nk  = int'(v.nacks[3*k +: 3]);
        att = (nk >= 4) ? 4 : nk + 1;
        for (int a = 0; a < att; a++) begin
          push_go({8'hBA, v.words[24*k +: 24]});
          ack_q.push_back((a < nk) ? 1'b1 : 1'b0);
        end
        push_end((nk >= 4) ? K_ERR : K_DONE, k);
      end
      for (int j = 0; j < 3; j++) if (v.mask[j]) arm_cnt[j]++;
      wait_sb_empty($sformatf("vec%0d_drain", t), 2000);
      @(negedge iCLK);
      check($sformatf("vec%0d_idle", t), 64'({oBUSY, iREQ}), 64'd0);
      check($sformatf("vec%0d_acks_used", t), 64'(ack_q.size()), 64'd0);
      ack_q.delete();
    end

    // Reset mid-transfer: one NACK, second attempt hangs in RUN, then reset.
    iREQ_DATA[23:0] = 24'h5AA5C3;
    push_go(32'hBA5AA5C3);
    push_go(32'hBA5AA5C3);
    ack_q.push_back(1'b1);
    arm_cnt[0]++;
    wait_sb_empty("pre_reset_frames", 500);
    repeat (4) @(negedge iCLK);
    check("pre_reset_go_busy", 64'({u_if.oI2C_GO, oBUSY}), 64'h3);
    #2 iRST_N = 1'b0;
    #1 check("async_reset", 64'({u_if.oI2C_GO, oBUSY, u_if.oI2C_CTRL_CLK, oDONE, oERR}), 64'd0);
    ack_q.delete();
    repeat (3) @(negedge iCLK);
    check("reset_hold_data", 64'(u_if.oI2C_DATA), 64'd0);
    // Retry count must restart at 0: three NACKs then ACK still completes.
    repeat (4) push_go(32'hBA5AA5C3);
    push_end(K_DONE, 0);
    ack_q.push_back(1'b1); ack_q.push_back(1'b1); ack_q.push_back(1'b1); ack_q.push_back(1'b0);
    iRST_N = 1'b1;
    wait_sb_empty("post_reset_drain", 1000);
    @(negedge iCLK);
    check("post_reset_idle", 64'({oBUSY, iREQ}), 64'd0);

    repeat (30) @(negedge iCLK);
    check("quiet_end", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_arbiter.md
Name: i2c_cmd_arbiter

Overview:
- Shares the single I2C_Controller write engine among N register-write requesters, for example the boot LUT sequencer, exposure adjust and zoom reconfigure.
- Generates the I2C control clock from iCLK.
- Round-robin grants requesters, wraps each 24-bit {sub_addr, data} word with the sensor slave address, and retries on NACK.
- Reports per-requester completion or failure.
- Sits between the CCD config logic and I2C_Controller.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- CLK_Freq, 50000000, iCLK frequency in Hz.
- I2C_Freq, 20000, control-clock half-period rate; divider terminal count = CLK_Freq/I2C_Freq.
- SLAVE_ADDR, 8'hBA, byte placed in bits [31:24] of oI2C_DATA.
- MAX_RETRY, 3, NACK retries after the first attempt before reporting an error.

Ports:
- iCLK  in  1  system clock
- iRST_N  in  1  asynchronous active-low reset
- iREQ  in  N_REQ  level request per requester; held until that requester's oDONE or oERR bit
- iREQ_DATA  in  24*N_REQ  requester k word at [24k+23:24k]; must be stable while iREQ[k]=1
- oDONE  out  N_REQ  one-iCLK pulse: requester k write ACKed
- oERR  out  N_REQ  one-iCLK pulse: requester k failed after MAX_RETRY retries
- oBUSY  out  1  high from grant until release
- oI2C_CTRL_CLK  out  1  divided clock to I2C_Controller.CLOCK
- oI2C_DATA  out  32  {SLAVE_ADDR, granted word}
- oI2C_GO  out  1  to I2C_Controller.GO
- iI2C_END  in  1  from I2C_Controller.END
- iI2C_ACK  in  1  from I2C_Controller.ACK; 1 = NACK

Behaviour:
- Reset values:
  - All outputs 0.
  - Divider and retry count 0.
  - RR pointer 0.
  - State IDLE.
  - Reset mid-transfer aborts immediately with GO=0; no oDONE or oERR is issued for the aborted transfer.
- Divider:
  - The counter increments each iCLK while below CLK_Freq/I2C_Freq.
  - At the terminal count it clears and oI2C_CTRL_CLK toggles.
  - tick = the iCLK cycle in which oI2C_CTRL_CLK toggles 0->1.
  - The FSM advances only on tick, except the oDONE/oERR pulses, which last exactly one iCLK.
- FSM states: IDLE, LOAD, RUN, REL, FIN.
  - IDLE: on tick, if any iREQ is high, choose the first requester at or after the RR pointer (wrapping). Latch its index and word, set oI2C_DATA, oBUSY=1, retry=0, go to LOAD.
  - LOAD: on tick, oI2C_GO=1, go to RUN.
  - RUN: on tick with iI2C_END=1, oI2C_GO=0.
    - ACK=0: go to FIN with result OK.
    - ACK=1 and retry<MAX_RETRY: retry++, go to REL, and re-issue afterwards.
    - ACK=1 and retry=MAX_RETRY: go to FIN with result ERR.
  - REL: wait on ticks until iI2C_END=0 with GO low (minimum one tick), then go to LOAD. Retries re-use the latched word.
  - FIN: pulse oDONE[idx] or oERR[idx] for one iCLK. Set the RR pointer to idx+1 mod N_REQ. Set oBUSY=0. Wait for iI2C_END=0, then go to IDLE.
- The latched word is used for the whole transaction. Changes to iREQ_DATA or a dropped iREQ during the transfer are ignored, and the completion pulse is still issued.
- Simultaneous requests:
  - Only one is granted per transaction.
  - Round-robin guarantees each active requester is serviced within N_REQ transactions.
- The RR pointer wraps from N_REQ-1 to 0.
- No back-to-back re-grant to the same requester while another requester is pending.
- oI2C_DATA holds its value from LOAD until the next grant.

Decomposition:
- Shared package i2c_cfg_pkg:
  - SLAVE_ADDR default.
  - Word width constants (ADDR_W=8, DATA_W=16, WORD_W=24).
  - FSM state encoding.
  - Divider terminal-count function.
- One sub-module, i2c_ctrl_clkgen: divider, oI2C_CTRL_CLK and tick.
- The RR pick is a function in the package, not a module.

Test Plan:
- Single request: iREQ=3'b001, word 24'h09_0450 -> oI2C_DATA=32'hBA090450, GO high one tick after grant. With a bench model returning END with ACK=0, exactly one oDONE[0] pulse follows, oBUSY returns to 0, and oERR stays 0.
- Contention: iREQ=3'b111 held, each dropped on its oDONE -> grant order 0,1,2, and each GO frame carries that requester's word.
- Fairness: req0 re-asserts immediately after its done while req1 is pending -> req1 is serviced before req0's second transfer.
- NACK recovery: model NACKs twice, then ACKs -> three GO pulses with identical oI2C_DATA, then oDONE. oERR stays 0.
- NACK exhaustion: always NACK with MAX_RETRY=3 -> four GO pulses, one oERR[k] pulse, no oDONE, and the arbiter returns to IDLE to serve the next requester.
- Reset mid-transfer: assert iRST_N=0 during RUN -> oI2C_GO, oBUSY and oI2C_CTRL_CLK are 0 asynchronously. After release, a still-pending request restarts from LOAD with retry=0.
